// File: rtl/arbiter_grant_hold.sv
// arbiter_grant_hold
// Registered grant-hold stage that sits behind the round-robin arbiter.
// It captures the arbiter's one-hot grant and holds it until the consumer
// acks it. While a grant is outstanding, it masks requests to the arbiter.
// It counts acked grants to produce the periodic replenish pulse. A hold
// timeout force-releases any grant the consumer never acknowledges.
module arbiter_grant_hold #(
   parameter int CLIENTS       = 4,
   parameter int REPLENISH_CNT = 8,
   parameter int MAX_HOLD      = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [CLIENTS-1:0]         i_req,
   output logic [CLIENTS-1:0]         ow_arb_req,
   input  logic [CLIENTS-1:0]         i_arb_grant,
   output logic                       ow_replenish,
   output logic                       o_grant_valid,
   output logic [CLIENTS-1:0]         o_grant,
   output logic [$clog2(CLIENTS)-1:0] o_grant_id,
   input  logic                       i_grant_ack,
   output logic                       o_timeout
);

   localparam int ID_W   = $clog2(CLIENTS);
   // A disabled feature (parameter 0) still keeps a 1-bit counter so that no
   // vector ends up with zero width.
   localparam int HOLD_W = (MAX_HOLD > 0)      ? $clog2(MAX_HOLD + 1)      : 1;
   localparam int REPL_W = (REPLENISH_CNT > 0) ? $clog2(REPLENISH_CNT + 1) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [REPL_W-1:0] REPL_LAST = REPL_W'((REPLENISH_CNT > 0) ? REPLENISH_CNT - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [REPL_W-1:0] REPL_ONE  = REPL_W'(1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CLIENTS-1:0]  r_grant;
   logic [CLIENTS-1:0]  w_grant_next;
   logic [ID_W-1:0]     r_grant_id;
   logic [ID_W-1:0]     w_grant_id_next;
   logic [HOLD_W-1:0]   r_hold;
   logic [HOLD_W-1:0]   w_hold_next;
   logic [REPL_W-1:0]   r_repl;
   logic [REPL_W-1:0]   w_repl_next;
   logic                r_replenish;
   logic                w_replenish_next;
   logic                r_timeout;
   logic                w_timeout_next;
   logic [CLIENTS-1:0]  w_lowest;
   logic [ID_W-1:0]     w_lowest_id;

   // Isolate the lowest set bit of the arbiter grant. This keeps the
   // captured grant one-hot even when the arbiter's grant has more than
   // one bit set.
   assign w_lowest = i_arb_grant & (~i_arb_grant + CLIENTS'(1));

   // Encode the index of the lowest set grant bit. The scan runs from the
   // top down, so the lowest set bit is written last and wins.
   always_comb begin
      w_lowest_id = '0;
      for (int i = CLIENTS - 1; i >= 0; i--) begin
         if (i_arb_grant[i]) begin
            w_lowest_id = ID_W'(i);
         end
      end
   end

   // Requests are only exposed to the arbiter while nothing is outstanding.
   assign ow_arb_req    = (r_state == ST_IDLE) ? i_req : '0;
   assign o_grant_valid = (r_state == ST_GRANT);
   assign o_grant       = r_grant;
   assign o_grant_id    = r_grant_id;
   assign ow_replenish  = r_replenish;
   assign o_timeout     = r_timeout;

   // Register the FSM state, the held grant, both counters and the pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_grant_id  <= '0;
         r_hold      <= '0;
         r_repl      <= '0;
         r_replenish <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_grant     <= w_grant_next;
         r_grant_id  <= w_grant_id_next;
         r_hold      <= w_hold_next;
         r_repl      <= w_repl_next;
         r_replenish <= w_replenish_next;
         r_timeout   <= w_timeout_next;
      end
   end

   // Next-state logic for the FSM: capture a grant, then release it on ack
   // or on timeout. Ack is checked first, so it wins a tie with the timeout.
   always_comb begin
      w_state_next     = r_state;
      w_grant_next     = r_grant;
      w_grant_id_next  = r_grant_id;
      w_hold_next      = r_hold;
      w_repl_next      = r_repl;
      w_replenish_next = 1'b0;
      w_timeout_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|i_arb_grant) begin
               w_state_next    = ST_GRANT;
               w_grant_next    = w_lowest;
               w_grant_id_next = w_lowest_id;
               w_hold_next     = '0;
            end
         end
         ST_GRANT: begin
            if (i_grant_ack) begin
               w_state_next    = ST_IDLE;
               w_grant_next    = '0;
               w_grant_id_next = '0;
               w_hold_next     = '0;
               if (REPLENISH_CNT > 0) begin
                  if (r_repl == REPL_LAST) begin
                     w_repl_next      = '0;
                     w_replenish_next = 1'b1;
                  end else begin
                     w_repl_next = r_repl + REPL_ONE;
                  end
               end
            end else if ((MAX_HOLD > 0) && (r_hold == HOLD_LAST)) begin
               w_state_next    = ST_IDLE;
               w_grant_next    = '0;
               w_grant_id_next = '0;
               w_hold_next     = '0;
               w_timeout_next  = 1'b1;
            end else begin
               w_hold_next = r_hold + HOLD_ONE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_arbiter_grant_hold.sv
// tb_arbiter_grant_hold
// Directed bench for arbiter_grant_hold. The main instance uses
// REPLENISH_CNT=8 and MAX_HOLD=4. A second instance has both features
// disabled (0) and shares the same inputs.
module tb_arbiter_grant_hold;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] arbGrant;
   logic       ack;

   logic [3:0] arbReq, grant, arbReq0, grant0;
   logic [1:0] gId, gId0;
   logic       replenish, gValid, timeout;
   logic       replenish0, gValid0, timeout0;

   int testsRun    = 0;
   int testsFailed = 0;

   arbiter_grant_hold #(.CLIENTS(4), .REPLENISH_CNT(8), .MAX_HOLD(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .ow_arb_req(arbReq),
      .i_arb_grant(arbGrant), .ow_replenish(replenish), .o_grant_valid(gValid),
      .o_grant(grant), .o_grant_id(gId), .i_grant_ack(ack), .o_timeout(timeout)
   );

   arbiter_grant_hold #(.CLIENTS(4), .REPLENISH_CNT(0), .MAX_HOLD(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .ow_arb_req(arbReq0),
      .i_arb_grant(arbGrant), .ow_replenish(replenish0), .o_grant_valid(gValid0),
      .o_grant(grant0), .o_grant_id(gId0), .i_grant_ack(ack), .o_timeout(timeout0)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and land 1 unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset both instances and return with the inputs idle.
   task automatic doReset();
      rst_n = 1'b0; arbGrant = 4'b0000; ack = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b0110; arbGrant = 4'b0110; ack = 1'b0;
      step(); step();
      testsRun++; if (gValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0b expected 0", gValid); end
      testsRun++; if (grant !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
      testsRun++; if (gId !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_id: got %0d expected 0", gId); end
      testsRun++; if (replenish !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_replenish: got %0b expected 0", replenish); end
      testsRun++; if (timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_timeout: got %0b expected 0", timeout); end
      testsRun++; if (arbReq !== 4'b0110) begin testsFailed++; $display("[TB] FAIL reset_arbreq: got %b expected 0110", arbReq); end
      rst_n = 1'b1; arbGrant = 4'b0000;
      step();
      testsRun++; if (gValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_release_valid: got %0b expected 0", gValid); end
   endtask

   task automatic test_basic();
      logic [3:0] toggles [3];
      toggles[0] = 4'b1011; toggles[1] = 4'b0001; toggles[2] = 4'b1111;
      req = 4'b0100; arbGrant = 4'b0100; ack = 1'b0;
      #1;
      testsRun++; if (arbReq !== 4'b0100) begin testsFailed++; $display("[TB] FAIL basic_idle_arbreq: got %b expected 0100", arbReq); end
      step();
      testsRun++; if (gValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_valid: got %0b expected 1", gValid); end
      testsRun++; if (grant !== 4'b0100) begin testsFailed++; $display("[TB] FAIL basic_grant: got %b expected 0100", grant); end
      testsRun++; if (gId !== 2'd2) begin testsFailed++; $display("[TB] FAIL basic_id: got %0d expected 2", gId); end
      testsRun++; if (arbReq !== 4'b0000) begin testsFailed++; $display("[TB] FAIL basic_arbreq_masked: got %b expected 0000", arbReq); end
      // Grant must hold while the arbiter output wanders; ack lands in the 4th GRANT cycle.
      for (int i = 0; i < 3; i++) begin
         arbGrant = toggles[i];
         step();
         testsRun++; if (grant !== 4'b0100 || gValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_hold%0d: got valid=%0b grant=%b expected 1 0100", i, gValid, grant); end
      end
      ack = 1'b1;
      step();
      ack = 1'b0; arbGrant = 4'b0000;
      testsRun++; if (gValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_ack_valid: got %0b expected 0", gValid); end
      testsRun++; if (grant !== 4'b0000 || gId !== 2'd0) begin testsFailed++; $display("[TB] FAIL basic_ack_clear: got grant=%b id=%0d expected 0000 0", grant, gId); end
      testsRun++; if (timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_ack_beats_timeout: got %0b expected 0", timeout); end
      testsRun++; if (arbReq !== 4'b0100) begin testsFailed++; $display("[TB] FAIL basic_ack_arbreq: got %b expected 0100", arbReq); end
   endtask

   task automatic test_multihot();
      arbGrant = 4'b1010;
      step();
      testsRun++; if (grant !== 4'b0010) begin testsFailed++; $display("[TB] FAIL multihot_grant: got %b expected 0010", grant); end
      testsRun++; if (gId !== 2'd1) begin testsFailed++; $display("[TB] FAIL multihot_id: got %0d expected 1", gId); end
      arbGrant = 4'b0000; ack = 1'b1;
      step();
      // An ack in IDLE must be ignored.
      step();
      ack = 1'b0;
      testsRun++; if (gValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_ack_ignored: got %0b expected 0", gValid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq   [5];
      logic [3:0] expG  [5];
      logic [1:0] expId [5];
      seq[0] = 4'b0001; expG[0] = 4'b0001; expId[0] = 2'd0;
      seq[1] = 4'b1000; expG[1] = 4'b1000; expId[1] = 2'd3;
      seq[2] = 4'b0100; expG[2] = 4'b0100; expId[2] = 2'd2;
      seq[3] = 4'b0010; expG[3] = 4'b0010; expId[3] = 2'd1;
      seq[4] = 4'b1001; expG[4] = 4'b0001; expId[4] = 2'd0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         arbGrant = seq[k]; ack = 1'b0;
         step();
         testsRun++; if (gValid !== 1'b1 || grant !== expG[k] || gId !== expId[k] || arbReq !== 4'b0000)
            begin testsFailed++; $display("[TB] FAIL b2b_grant%0d: got v=%0b g=%b id=%0d req=%b expected 1 %b %0d 0000", k, gValid, grant, gId, arbReq, expG[k], expId[k]); end
         arbGrant = ~seq[k]; ack = 1'b1;
         step();
         testsRun++; if (gValid !== 1'b0 || grant !== 4'b0000 || arbReq !== 4'b1111)
            begin testsFailed++; $display("[TB] FAIL b2b_idle%0d: got v=%0b g=%b req=%b expected 0 0000 1111", k, gValid, grant, arbReq); end
      end
      ack = 1'b0; arbGrant = 4'b0000;
   endtask

   task automatic test_replenish();
      logic expRep;
      doReset();
      req = 4'b0001;
      for (int j = 1; j <= 16; j++) begin
         arbGrant = 4'b0001; ack = 1'b0;
         step();
         testsRun++; if (gValid !== 1'b1 || replenish !== 1'b0) begin testsFailed++; $display("[TB] FAIL repl_grant%0d: got v=%0b rep=%0b expected 1 0", j, gValid, replenish); end
         arbGrant = 4'b0000; ack = 1'b1;
         step();
         expRep = (j == 8) || (j == 16);
         testsRun++; if (replenish !== expRep) begin testsFailed++; $display("[TB] FAIL repl_pulse%0d: got %0b expected %0b", j, replenish, expRep); end
         testsRun++; if (replenish0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL repl_disabled%0d: got %0b expected 0", j, replenish0); end
      end
      ack = 1'b0;
   endtask

   task automatic test_timeout();
      logic expRep;
      doReset();
      req = 4'b0100; arbGrant = 4'b0100;
      step();
      arbGrant = 4'b0000;
      for (int i = 1; i <= 3; i++) begin
         step();
         testsRun++; if (gValid !== 1'b1 || timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_hold%0d: got v=%0b to=%0b expected 1 0", i, gValid, timeout); end
      end
      step();
      testsRun++; if (gValid !== 1'b0 || timeout !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_fire: got v=%0b to=%0b expected 0 1", gValid, timeout); end
      testsRun++; if (grant !== 4'b0000 || arbReq !== 4'b0100) begin testsFailed++; $display("[TB] FAIL to_release: got g=%b req=%b expected 0000 0100", grant, arbReq); end
      testsRun++; if (gValid0 !== 1'b1 || timeout0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_disabled: got v=%0b to=%0b expected 1 0", gValid0, timeout0); end
      step();
      testsRun++; if (timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_one_pulse: got %0b expected 0", timeout); end
      // Drain the no-timeout instance; the main instance ignores this ack in IDLE.
      ack = 1'b1;
      step();
      ack = 1'b0;
      testsRun++; if (gValid0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_disabled_drain: got %0b expected 0", gValid0); end
      // The timed-out grant is not counted: the pulse needs 8 fresh acks.
      for (int j = 1; j <= 8; j++) begin
         arbGrant = 4'b0100; ack = 1'b0;
         step();
         arbGrant = 4'b0000; ack = 1'b1;
         step();
         expRep = (j == 8);
         testsRun++; if (replenish !== expRep) begin testsFailed++; $display("[TB] FAIL to_not_counted%0d: got %0b expected %0b", j, replenish, expRep); end
      end
      ack = 1'b0;
   endtask

   task automatic test_reset_mid_grant();
      logic expRep;
      doReset();
      req = 4'b1001;
      for (int j = 0; j < 3; j++) begin
         arbGrant = 4'b1000; ack = 1'b0; step();
         arbGrant = 4'b0000; ack = 1'b1; step();
      end
      ack = 1'b0; arbGrant = 4'b1000;
      step();
      arbGrant = 4'b0000;
      testsRun++; if (gValid !== 1'b1 || gId !== 2'd3) begin testsFailed++; $display("[TB] FAIL mid_pre: got v=%0b id=%0d expected 1 3", gValid, gId); end
      #2 rst_n = 1'b0;
      #1;
      testsRun++; if (gValid !== 1'b0 || grant !== 4'b0000 || gId !== 2'd0) begin testsFailed++; $display("[TB] FAIL mid_async_drop: got v=%0b g=%b id=%0d expected 0 0000 0", gValid, grant, gId); end
      testsRun++; if (arbReq !== 4'b1001 || timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_async_req: got req=%b to=%0b expected 1001 0", arbReq, timeout); end
      step();
      rst_n = 1'b1;
      step();
      testsRun++; if (gValid !== 1'b0 || arbReq !== 4'b1001 || timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_after: got v=%0b req=%b to=%0b expected 0 1001 0", gValid, arbReq, timeout); end
      // The replenish counter restarted from zero.
      for (int j = 1; j <= 8; j++) begin
         arbGrant = 4'b0001; ack = 1'b0; step();
         arbGrant = 4'b0000; ack = 1'b1; step();
         expRep = (j == 8);
         testsRun++; if (replenish !== expRep) begin testsFailed++; $display("[TB] FAIL mid_repl%0d: got %0b expected %0b", j, replenish, expRep); end
      end
      ack = 1'b0;
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      rst_n = 1'b0; req = 4'b0000; arbGrant = 4'b0000; ack = 1'b0;
      test_reset();
      test_basic();
      test_multihot();
      test_back_to_back();
      test_replenish();
      test_timeout();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/arbiter_grant_hold.md
# arbiter_grant_hold

Registered grant-hold stage that sits directly downstream of the round-robin arbiter. It captures the arbiter's combinational one-hot grant, holds it stable as a registered grant (one-hot plus encoded ID) until the consumer acknowledges it, and gates the arbiter's request inputs while a grant is outstanding. It also counts completed grants to generate the arbiter's periodic replenish pulse, and it retires stuck grants with a hold timeout.

## Interface
- CLIENTS, 4, number of requesters (>= 2)
- REPLENISH_CNT, 8, completed grants per replenish pulse; 0 disables replenish (ow_replenish stays 0)
- MAX_HOLD, 16, maximum GRANT-state cycles before forced release; 0 disables the timeout
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_req  input  CLIENTS  raw client requests
- ow_arb_req  output  CLIENTS  combinational requests to the arbiter: i_req in IDLE, all-zero in GRANT
- i_arb_grant  input  CLIENTS  combinational grant from the arbiter
- ow_replenish  output  1  to arbiter replenish input; registered, one-cycle pulse
- o_grant_valid  output  1  registered grant outstanding
- o_grant  output  CLIENTS  registered one-hot grant; zero when o_grant_valid=0
- o_grant_id  output  $clog2(CLIENTS)  binary index of o_grant; zero when o_grant_valid=0
- i_grant_ack  input  1  consumer completes the outstanding grant
- o_timeout  output  1  one-cycle pulse when a grant is force-released

## Operation
- FSM states:
  - IDLE (reset state): ow_arb_req=i_req. If i_arb_grant != 0, register it into o_grant, encode o_grant_id, clear the hold counter, and go to GRANT.
  - GRANT: o_grant_valid=1. o_grant and o_grant_id stay stable and ow_arb_req=0. i_grant_ack=1 returns the FSM to IDLE.
- Multi-hot i_arb_grant: capture only the lowest set bit. o_grant is always one-hot, and o_grant_id is that bit's index.
- i_arb_grant is ignored in GRANT. i_grant_ack is ignored in IDLE.
- Hold counter:
  - Width $clog2(MAX_HOLD+1).
  - Increments each GRANT cycle without an ack.
  - When MAX_HOLD>0, the counter = MAX_HOLD-1, and there is no ack, the FSM goes to IDLE and pulses o_timeout in the next cycle.
- If ack and timeout occur in the same cycle, ack wins: no o_timeout, and the grant is counted.
- Replenish counter:
  - Width $clog2(REPLENISH_CNT+1).
  - Increments on each acked grant. Timeouts are not counted.
  - When the counter = REPLENISH_CNT-1 and an ack occurs, the counter wraps to 0 and ow_replenish=1 in the next cycle only.
- Reset (asynchronous, any time including mid-grant):
  - State IDLE; both counters 0.
  - o_grant_valid, o_grant, o_grant_id, ow_replenish and o_timeout all 0.
  - ow_arb_req follows i_req immediately.
  - Any outstanding grant is dropped without ack or timeout.

## Timing
- Cycle N, IDLE, i_arb_grant != 0 -> cycle N+1: o_grant_valid=1, o_grant/o_grant_id valid, ow_arb_req=0.
- Cycle M, GRANT, i_grant_ack=1 -> cycle M+1: IDLE, o_grant_valid=0, o_grant=0, ow_arb_req=i_req. The earliest next valid grant is cycle M+2.
- Maximum throughput is one grant per 2 cycles. Ack in the first GRANT cycle is legal.
- ow_replenish is high in cycle M+1, the IDLE cycle in which the next arbitration occurs.
- Timeout: entry at cycle N+1 with no ack -> o_timeout=1 and o_grant_valid=0 at cycle N+1+MAX_HOLD.
- No combinational path from i_grant_ack to any output. ow_arb_req depends combinationally only on i_req and state.

## Test plan
- Reset, then i_req=4'b0100 with i_arb_grant=4'b0100 -> next cycle o_grant_valid=1, o_grant=4'b0100, o_grant_id=2, ow_arb_req=0; ack 3 cycles later -> valid=0 next cycle; all outputs 0 during reset.
- Back-to-back clients, acking every GRANT cycle immediately -> grants valid on alternating cycles; o_grant stable through GRANT despite i_arb_grant toggling.
- REPLENISH_CNT=8, 8 acked grants -> ow_replenish=1 exactly one cycle after the 8th ack; counter wraps, next pulse after 16th ack; with REPLENISH_CNT=0 never asserted.
- MAX_HOLD=4, no ack -> o_timeout=1 and o_grant_valid=0 exactly 4 cycles after valid rose; timeout grant not counted toward replenish; ack on the 4th GRANT cycle -> no o_timeout.
- i_arb_grant=4'b1010 in IDLE -> o_grant=4'b0010, o_grant_id=1.
- Assert i_rst_n=0 mid-GRANT (asynchronous, between edges) -> o_grant_valid, o_grant and o_grant_id drop immediately; after release, IDLE with counters 0 and ow_arb_req=i_req.
